// File: rtl/gf_nb_frob_seq_if.sv
// Operand/result handshake bundle for the normal-basis Frobenius engine.
// The master side presents operands and consumes results; the slave side is the engine.
interface gf_nb_frob_seq_if #(
    parameter int N  = 8,
    parameter int KW = $clog2(N) + 1
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  A;
    logic [KW-1:0] K;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  Q;
    logic          busy;

    modport master (
        output in_valid, A, K, out_ready,
        input  in_ready, out_valid, Q, busy
    );

    modport slave (
        input  in_valid, A, K, out_ready,
        output in_ready, out_valid, Q, busy
    );
endinterface

// File: rtl/gf_nb_frob_seq.sv
// Sequential Frobenius power A^(2^K) over GF(2^N) in normal basis.
// Each squaring is a left rotation, so the engine rotates at most STEP positions per cycle.
module gf_nb_frob_seq #(
    parameter int N    = 8,
    parameter int STEP = 1,
    parameter int KW   = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             rst,
    gf_nb_frob_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [KW-1:0] STEP_W = KW'(STEP);

    state_e        state_q, state_d;
    logic [KW-1:0] rem_q, rem_d;
    logic [N-1:0]  data_q, data_d;
    logic [N-1:0]  q_q, q_d;
    logic [KW-1:0] step_s;
    logic [KW-1:0] k_mod_s;

    // Restoring reduction of K by N; works for any N, collapses to a mask for powers of two.
    function automatic logic [KW-1:0] mod_n(input logic [KW-1:0] k);
        logic [2*KW-1:0] acc;
        logic [2*KW-1:0] sub;
        acc = {{KW{1'b0}}, k};
        for (int i = KW - 1; i >= 0; i--) begin
            sub = (2*KW)'(N) << i;
            acc = (acc >= sub) ? (acc - sub) : acc;
        end
        return acc[KW-1:0];
    endfunction

    function automatic logic [N-1:0] rotl(input logic [N-1:0] d, input logic [KW-1:0] s);
        logic [2*N-1:0] w;
        w = {d, d} << s;
        return w[2*N-1:N];
    endfunction

    // Next-state, rotation datapath and result capture.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        data_d  = data_q;
        k_mod_s = mod_n(bus.K);
        step_s  = (rem_q < STEP_W) ? rem_q : STEP_W;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.A;
                    rem_d   = k_mod_s;
                    state_d = (k_mod_s == {KW{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                data_d = rotl(data_q, step_s);
                rem_d  = rem_q - step_s;
                if (rem_q == step_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = {KW{1'b0}};
                data_d  = {N{1'b0}};
            end
        endcase
        // Q tracks the data register so it is already valid on the edge that enters DONE.
        q_d = data_d;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= {KW{1'b0}};
            data_q  <= {N{1'b0}};
            q_q     <= {N{1'b0}};
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            q_q     <= q_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.Q         = q_q;
endmodule

// File: tb/tb_gf_nb_frob_seq.sv
// Bench for gf_nb_frob_seq: four configurations checked against a rotate-by-squaring model,
// a directed vector table, random operands, backpressure and reset corner cases.
module tb_gf_nb_frob_seq;
    localparam int NS    [4] = '{2, 8, 8, 5};
    localparam int STEPS [4] = '{1, 1, 3, 2};
    localparam int KWS   [4] = '{2, 4, 4, 4};

    typedef struct {
        int         cfg;
        logic [7:0] a;
        logic [3:0] k;
        logic [7:0] q;
        int         lat;
    } vec_t;

    logic       clk;
    logic [3:0] rst_v;
    int         n_cmp;
    int         n_bad;
    vec_t       tbl [14];

    gf_nb_frob_seq_if #(.N(2)) b0 ();
    gf_nb_frob_seq_if #(.N(8)) b1 ();
    gf_nb_frob_seq_if #(.N(8)) b2 ();
    gf_nb_frob_seq_if #(.N(5)) b3 ();

    gf_nb_frob_seq #(.N(2), .STEP(1)) u0 (.clk(clk), .rst(rst_v[0]), .bus(b0.slave));
    gf_nb_frob_seq #(.N(8), .STEP(1)) u1 (.clk(clk), .rst(rst_v[1]), .bus(b1.slave));
    gf_nb_frob_seq #(.N(8), .STEP(3)) u2 (.clk(clk), .rst(rst_v[2]), .bus(b2.slave));
    gf_nb_frob_seq #(.N(5), .STEP(2)) u3 (.clk(clk), .rst(rst_v[3]), .bus(b3.slave));

    always #5 clk = ~clk;

    // Reference: r = K mod N successive squarings, each moving bit i to bit (i+1) mod N.
    function automatic logic [7:0] ref_q(input int c, input logic [7:0] a, input int k);
        int         n;
        int         r;
        logic [7:0] cur;
        logic [7:0] nxt;
        n   = NS[c];
        r   = k % n;
        cur = a;
        for (int t = 0; t < r; t++) begin
            nxt = 8'h00;
            for (int i = 0; i < n; i++) nxt[(i + 1) % n] = cur[i];
            cur = nxt;
        end
        return cur;
    endfunction

    function automatic int ref_lat(input int c, input int k);
        int r;
        r = k % NS[c];
        return (r == 0) ? 1 : 1 + (r + STEPS[c] - 1) / STEPS[c];
    endfunction

    task automatic drive(input int c, input logic v, input logic [7:0] a, input logic [3:0] k,
                         input logic ordy);
        case (c)
            0: begin b0.in_valid = v; b0.A = a[1:0]; b0.K = k[1:0]; b0.out_ready = ordy; end
            1: begin b1.in_valid = v; b1.A = a;      b1.K = k;      b1.out_ready = ordy; end
            2: begin b2.in_valid = v; b2.A = a;      b2.K = k;      b2.out_ready = ordy; end
            3: begin b3.in_valid = v; b3.A = a[4:0]; b3.K = k;      b3.out_ready = ordy; end
            default: ;
        endcase
    endtask

    task automatic sample(input int c, output logic ir, output logic ov, output logic bz,
                          output logic [7:0] q);
        case (c)
            0: begin ir = b0.in_ready; ov = b0.out_valid; bz = b0.busy; q = {6'd0, b0.Q}; end
            1: begin ir = b1.in_ready; ov = b1.out_valid; bz = b1.busy; q = b1.Q; end
            2: begin ir = b2.in_ready; ov = b2.out_valid; bz = b2.busy; q = b2.Q; end
            3: begin ir = b3.in_ready; ov = b3.out_valid; bz = b3.busy; q = {3'd0, b3.Q}; end
            default: begin ir = 1'b0; ov = 1'b0; bz = 1'b0; q = 8'h00; end
        endcase
    endtask

    task automatic chk(input string nm, input int c, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    function automatic logic [7:0] rnd_a(input int c);
        logic [7:0] m;
        m = 8'((1 << NS[c]) - 1);
        return 8'($urandom) & m;
    endfunction

    // After the accept edge, count cycles until out_valid (bounded) and check the result.
    task automatic wait_result(input int c, input logic [7:0] eq, input int elat, input string nm);
        logic ir, ov, bz;
        logic [7:0] q;
        int lat;
        lat = 1;
        sample(c, ir, ov, bz, q);
        while (!ov && lat < 64) begin
            @(negedge clk);
            lat++;
            sample(c, ir, ov, bz, q);
        end
        chk({nm, "_valid"}, c, int'(ov), 1);
        chk({nm, "_lat"}, c, lat, elat);
        chk({nm, "_q"}, c, int'(q), int'(eq));
    endtask

    task automatic do_op(input int c, input logic [7:0] a, input logic [3:0] k,
                         input logic [7:0] eq, input int elat, input string nm);
        logic ir, ov, bz;
        logic [7:0] q;
        @(negedge clk);
        sample(c, ir, ov, bz, q);
        chk({nm, "_in_ready"}, c, int'(ir), 1);
        drive(c, 1'b1, a, k, 1'b1);
        @(posedge clk);
        @(negedge clk);
        // Scramble A/K after accept: they must not matter any more.
        drive(c, 1'b0, 8'($urandom), 4'($urandom), 1'b1);
        wait_result(c, eq, elat, nm);
    endtask

    initial begin
        logic ir, ov, bz;
        logic [7:0] q;
        logic [7:0] a, a2, eq;
        logic [3:0] k, k2;
        int rc;

        n_cmp = 0;
        n_bad = 0;
        clk   = 1'b0;
        rst_v = 4'hF;
        for (int c = 0; c < 4; c++) drive(c, 1'b0, 8'h00, 4'h0, 1'b0);

        tbl[0]  = '{0, 8'h01, 4'd1,  8'h02, 2};
        tbl[1]  = '{0, 8'h03, 4'd1,  8'h03, 2};
        tbl[2]  = '{0, 8'h02, 4'd2,  8'h02, 1};
        tbl[3]  = '{0, 8'h02, 4'd3,  8'h01, 2};
        tbl[4]  = '{1, 8'h01, 4'd3,  8'h08, 4};
        tbl[5]  = '{1, 8'h80, 4'd1,  8'h01, 2};
        tbl[6]  = '{1, 8'hA5, 4'd8,  8'hA5, 1};
        tbl[7]  = '{1, 8'h01, 4'd15, 8'h80, 8};
        tbl[8]  = '{2, 8'h81, 4'd7,  8'hC0, 4};
        tbl[9]  = '{2, 8'h81, 4'd0,  8'h81, 1};
        tbl[10] = '{2, 8'h01, 4'd6,  8'h40, 3};
        tbl[11] = '{3, 8'h03, 4'd7,  8'h0C, 2};
        tbl[12] = '{3, 8'h10, 4'd1,  8'h01, 2};
        tbl[13] = '{3, 8'h15, 4'd4,  8'h1A, 3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_v = 4'h0;
        for (int c = 0; c < 4; c++) begin
            sample(c, ir, ov, bz, q);
            chk("rst_in_ready", c, int'(ir), 1);
            chk("rst_out_valid", c, int'(ov), 0);
            chk("rst_busy", c, int'(bz), 0);
            chk("rst_q", c, int'(q), 0);
        end

        for (int i = 0; i < 14; i++)
            do_op(tbl[i].cfg, tbl[i].a, tbl[i].k, tbl[i].q, tbl[i].lat, "vec");

        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 30; i++) begin
                a = rnd_a(c);
                k = 4'($urandom_range(0, (1 << KWS[c]) - 1));
                do_op(c, a, k, ref_q(c, a, int'(k)), ref_lat(c, int'(k)), "rnd");
            end
        end

        // Backpressure: result held 10 cycles while a second operand waits.
        for (int c = 0; c < 4; c++) begin
            a  = rnd_a(c);
            k  = 4'($urandom_range(1, NS[c] - 1));
            a2 = rnd_a(c);
            k2 = 4'($urandom_range(0, (1 << KWS[c]) - 1));
            eq = ref_q(c, a, int'(k));
            @(negedge clk);
            drive(c, 1'b1, a, k, 1'b0);
            @(posedge clk);
            @(negedge clk);
            drive(c, 1'b0, 8'h00, 4'h0, 1'b0);
            wait_result(c, eq, ref_lat(c, int'(k)), "bp");
            drive(c, 1'b1, a2, k2, 1'b0);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                sample(c, ir, ov, bz, q);
                chk("bp_hold_valid", c, int'(ov), 1);
                chk("bp_hold_q", c, int'(q), int'(eq));
                chk("bp_hold_in_ready", c, int'(ir), 0);
            end
            drive(c, 1'b1, a2, k2, 1'b1);
            @(negedge clk);
            sample(c, ir, ov, bz, q);
            chk("bp_rel_in_ready", c, int'(ir), 1);
            chk("bp_rel_busy", c, int'(bz), 0);
            chk("bp_rel_valid", c, int'(ov), 0);
            @(posedge clk);
            @(negedge clk);
            drive(c, 1'b0, 8'h00, 4'h0, 1'b1);
            wait_result(c, ref_q(c, a2, int'(k2)), ref_lat(c, int'(k2)), "bp_next");
        end

        // Reset in the middle of RUN: the operand must vanish.
        for (int c = 0; c < 4; c++) begin
            a  = rnd_a(c) | 8'h01;
            k  = (c == 1) ? 4'd5 : 4'(NS[c] - 1);
            rc = (int'(k) % NS[c] + STEPS[c] - 1) / STEPS[c];
            @(negedge clk);
            drive(c, 1'b1, a, k, 1'b1);
            @(posedge clk);
            if (rc >= 2) @(posedge clk);
            @(negedge clk);
            drive(c, 1'b0, 8'h00, 4'h0, 1'b1);
            rst_v[c] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst_v[c] = 1'b0;
            sample(c, ir, ov, bz, q);
            chk("mid_rst_in_ready", c, int'(ir), 1);
            chk("mid_rst_valid", c, int'(ov), 0);
            chk("mid_rst_q", c, int'(q), 0);
            chk("mid_rst_busy", c, int'(bz), 0);
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                sample(c, ir, ov, bz, q);
                chk("mid_rst_no_result", c, int'(ov | bz), 0);
            end
        end

        // Reset coinciding with an accept: nothing is captured.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rst_v[c] = 1'b1;
            drive(c, 1'b1, rnd_a(c), 4'd0, 1'b0);
            @(posedge clk);
            @(negedge clk);
            rst_v[c] = 1'b0;
            drive(c, 1'b0, 8'h00, 4'h0, 1'b0);
            sample(c, ir, ov, bz, q);
            chk("rst_acc_busy", c, int'(bz), 0);
            chk("rst_acc_valid", c, int'(ov), 0);
            chk("rst_acc_in_ready", c, int'(ir), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gf_nb_frob_seq.md
Name: gf_nb_frob_seq

Overview:
- Sequential Frobenius-power engine over GF(2^N) in normal-basis representation. Computes Q = A^(2^K) as a cyclic left rotation of the coefficient vector, applying at most STEP positions per cycle.
- Successor of the combinational GF(2^2) normal-basis squarer. N=2, K=1 gives the same result: square, which is also the inverse in GF(2^2).
- Used by iterative inversion / exponentiation datapaths in the S-box variants, with valid/ready handshakes on both sides.

Parameters:
- N, 8, field degree = data width in bits (N >= 2).
- STEP, 1, maximum rotation positions applied per RUN cycle (1 <= STEP <= N).
- KW, $clog2(N)+1, width of the K exponent input.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- A  input  N  operand in normal basis; bit i is the coefficient of beta^(2^i).
- K  input  KW  exponent count; effective count r = K mod N.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Q  output  N  result A^(2^r), normal basis.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (synchronous, active-high), taking effect at the next edge:
  - Outputs: in_ready=1, out_valid=0, busy=0, Q=0.
  - State: state=IDLE, rem=0, data reg=0.
  - Reset overrides every other event, including mid-RUN and DONE; any in-flight result is discarded.
- Squaring rule: one squaring is rotate-left by 1, i.e. new[(i+1) mod N] = old[i]. Applying it r times gives rotate-left by r.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture data<=A and rem<=K mod N. Go to DONE if r==0, else RUN.
  - RUN: each cycle set s = min(STEP, rem), then data <= rotl(data, s) and rem <= rem - s. When rem-s==0, go to DONE.
  - DONE: out_valid=1, Q=data. On out_ready, go to IDLE.
- Handshake:
  - in_ready=1 only in IDLE. There is no overlap: one operation in flight.
  - out_valid stays asserted and Q stays stable until out_ready is sampled high. Backpressure has no cycle limit.
  - in_valid while in_ready=0 is ignored; the source must hold it.
  - A and K are sampled only on the accept edge. Later changes have no effect.
- Q is a registered copy of data. It reads 0 or a stale value outside DONE; consumers qualify it with out_valid.
- Latency, accept edge to out_valid high:
  - r==0: 1 cycle.
  - otherwise: 1 + ceil(r/STEP) cycles.
- Throughput: one result per latency+1 cycles when out_ready is held high.
- K reduction: K mod N handles K >= N, e.g. N=5, K=7 gives r=2. When N is a power of two this is a bit mask; otherwise use a compare-subtract loop over the KW range, combinational at accept.
- Simultaneous events:
  - DONE with out_ready high moves to IDLE. The next accept happens in the following cycle, not the same one (in_ready is still 0 in DONE).
  - rst together with an accept: reset wins and nothing is captured.
- busy = (state != IDLE).

Test Plan:
- N=2, STEP=1, A=2'b01, K=1 -> Q=2'b10 with out_valid high 2 cycles after accept. Then A=2'b11, K=1 -> Q=2'b11.
- N=8, STEP=1, A=8'h01, K=3 -> 3 RUN cycles; out_valid high 4 cycles after accept, Q=8'h08.
- N=8, STEP=3, A=8'h81, K=7 -> RUN steps 3,3,1; out_valid at accept+4, Q=8'hC0. Same operand with K=0 -> Q=8'h81 at accept+1.
- N=5, STEP=2, A=5'b00011, K=7 (r=2) -> Q=5'b01100 at accept+2.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> Q and out_valid stable, in_ready=0, a new in_valid is not accepted. Release -> IDLE next cycle, next operand accepted one cycle later.
- Assert rst for 1 cycle mid-RUN (N=8, K=5, STEP=1, second RUN cycle) -> next cycle IDLE, out_valid=0, Q=0, in_ready=1, and no result ever emerges for that operand.
